abs_encoder_emulator: RTL
=========================

Name: abs_encoder_emulator

Overview:
- Slave-side model of the absolute-encoder serial link, placed at the other end of the line from the FOC encoder interface.
- Receives a one-byte request (control field, CF) on the RS485 RX path and returns a response frame carrying the injected position and status bytes.
- Drives the transceiver direction pin around each response.
- Used for hardware-in-the-loop and closed-loop bench runs of the encoder datapath without a physical encoder.

Parameters:
- CLKS_PER_BIT, 40, clocks per UART bit (100 MHz / 2.5 Mbps).
- TURN_CLKS, 300, clocks from request stop-bit sample to first response start bit.
- DIR_LEAD, 40, clocks oDir is asserted before the first response start bit; DIR_LEAD < TURN_CLKS.
- ENID, 8'h17, encoder ID byte returned for CF 8'h8A.

Ports:
- nclk_100m  in  1  system clock, 100 MHz.
- iRst_n  in  1  reset.
- iRx  in  1  request line from controller TX; idle high; asynchronous to nclk_100m.
- iPosition  in  24  single-turn position to report.
- iStatus  in  8  status field (SF) to report.
- oTx  out  1  response line to controller RX; idle high.
- oDir  out  1  transceiver driver enable; 1 = emulator driving.
- oBusy  out  1  high from valid request accepted until response complete.
- oErr  out  1  one-cycle pulse on framing error or unknown CF.
- oReq_cnt  out  16  count of valid requests answered; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset is asynchronous, active-low, on iRst_n; clock is nclk_100m.
- Reset values: oTx=1, oDir=0, oBusy=0, oErr=0, oReq_cnt=0, FSM=IDLE, rx synchronizer flops = 1.
- UART format: 8N1, LSB first, CLKS_PER_BIT clocks per bit.
- iRx passes through a 2-flop synchronizer; all rx decisions use the synchronized value.
- FSM states: IDLE, RX_START, RX_DATA, RX_STOP, TURN, TX, WAIT_IDLE.
- IDLE: synchronized falling edge on iRx -> RX_START; bit counter cleared.
- RX_START: sample at CLKS_PER_BIT/2. High = false start -> IDLE, no oErr. Low -> RX_DATA.
- RX_DATA: sample 8 bits, each one CLKS_PER_BIT after the previous sample.
- RX_STOP: sample one CLKS_PER_BIT after the last data bit.
  - Stop bit low: oErr pulse -> WAIT_IDLE.
  - Stop bit high, CF in {8'h02, 8'h8A}: latch CF, snapshot iPosition and iStatus in that same cycle, oBusy=1 -> TURN.
  - Stop bit high, other CF: oErr pulse -> IDLE, no response.
- WAIT_IDLE: stay until synchronized iRx has been high for CLKS_PER_BIT consecutive clocks -> IDLE.
- TURN: counts TURN_CLKS clocks. oDir rises when count reaches TURN_CLKS-DIR_LEAD. At count TURN_CLKS -> TX.
- Response byte sequence, sent back-to-back with no idle gap:
  - CF 8'h02: CF, SF, POS[7:0], POS[15:8], POS[23:16], CRC (6 bytes).
  - CF 8'h8A: CF, SF, ENID, CRC (4 bytes).
- CRC = XOR of all preceding response bytes; accumulated as bytes are loaded.
- End of response: at the end of the final stop bit, oDir=0, oBusy=0, oReq_cnt increments (one cycle), FSM -> IDLE. oTx stays 1.
- Request edges on iRx during TURN/TX are ignored; no error is flagged.
- The snapshot is frozen for the whole response; iPosition changes mid-response do not appear until the next request.
- iRst_n asserted mid-frame: oTx=1 and oDir=0 immediately (asynchronous); the partial frame is abandoned.
- Latency: first response start bit begins exactly TURN_CLKS clocks after the stop-bit sample cycle.

Test Plan:
- iPosition=24'h123456, iStatus=8'h00, send CF 8'h02 -> oTx bytes 02,00,56,34,12,72. Each bit 40 clocks. Start bit 300 clocks after stop sample. oDir high 40 clocks before start, low at end of last stop bit. oReq_cnt=1.
- iStatus=8'h40, send CF 8'h8A -> bytes 8A,40,17,DD; 4×10×40 = 1600 clocks of oDir high after lead.
- Send CF 8'h55 -> single oErr pulse after stop sample; oTx stays 1, oDir stays 0, oReq_cnt unchanged.
- Send 8'h02 with stop bit forced low -> oErr pulse; line held high 40 clocks, then valid 8'h02 request answered normally.
- 10-clock low glitch on iRx in IDLE -> false start rejected, no oErr, no response; iPosition change during TX -> response carries the snapshotted value.
- Preload 65535 responses via force, then one more request -> oReq_cnt wraps to 0. Assert iRst_n low during byte 3 of a response -> oTx=1 and oDir=0 immediately; after release, the next request is answered.

Source files
------------

// File: rtl/abs_encoder_emulator_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : abs_encoder_emulator_if
//  Purpose  : Bundles the serial link and the injected encoder data of the
//             absolute-encoder emulator.
//  Signals  : iRx        request line from controller TX (idle high)
//             iPosition  24-bit single-turn position to report
//             iStatus    8-bit status field to report
//             oTx        response line to controller RX (idle high)
//             oDir       transceiver driver enable, 1 = emulator driving
//             oBusy      high from accepted request until response complete
//             oErr       one-cycle pulse on framing error / unknown CF
//             oReq_cnt   count of answered requests (wraps)
//  Modports : slave  - emulator side
//             master - controller / bench side
//  Revision : 1.0  initial release
// ============================================================================
interface abs_encoder_emulator_if;
   logic        iRx;
   logic [23:0] iPosition;
   logic [7:0]  iStatus;
   logic        oTx;
   logic        oDir;
   logic        oBusy;
   logic        oErr;
   logic [15:0] oReq_cnt;

   modport slave (
      input  iRx, iPosition, iStatus,
      output oTx, oDir, oBusy, oErr, oReq_cnt
   );

   modport master (
      output iRx, iPosition, iStatus,
      input  oTx, oDir, oBusy, oErr, oReq_cnt
   );
endinterface
`default_nettype wire

// File: rtl/abs_encoder_emulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : abs_encoder_emulator
//  Purpose  : Slave-side emulator of an absolute-encoder serial link. Receives
//             a one-byte control field (CF) over UART 8N1, and for CF 8'h02
//             or 8'h8A answers with a frame carrying a snapshot of the
//             injected position/status, terminated by an XOR checksum.
//             The RS485 direction pin is raised DIR_LEAD clocks before the
//             first response start bit and dropped after the last stop bit.
//  Ports    : nclk_100m  system clock (100 MHz)
//             iRst_n     asynchronous active-low reset
//             bus        abs_encoder_emulator_if.slave (link + data + status)
//  Revision : 1.0  initial release
// ============================================================================
module abs_encoder_emulator #(
   parameter int         CLKS_PER_BIT = 40,
   parameter int         TURN_CLKS    = 300,
   parameter int         DIR_LEAD     = 40,
   parameter logic [7:0] ENID         = 8'h17
) (
   input wire                    nclk_100m,
   input wire                    iRst_n,
   abs_encoder_emulator_if.slave bus
);

   localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] c_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] c_TURN_LAST = 16'(TURN_CLKS - 1);
   localparam logic [15:0] c_DIR_ON    = 16'(TURN_CLKS - DIR_LEAD - 1);
   localparam logic [7:0]  c_CF_POS    = 8'h02;
   localparam logic [7:0]  c_CF_ID     = 8'h8A;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_STOP   = 3'd3,
      TURN      = 3'd4,
      TX        = 3'd5,
      WAIT_IDLE = 3'd6
   } state_t;

   state_t      rState;
   state_t      wStateNxt;

   logic        rRxMeta;
   logic        rRxSync;
   logic        rRxPrev;

   logic [15:0] rClkCnt;
   logic [3:0]  rBitCnt;
   logic [7:0]  rRxShift;
   logic [7:0]  rCf;
   logic [7:0]  rSf;
   logic [23:0] rPos;
   logic [7:0]  rCrc;
   logic [2:0]  rByteIdx;
   logic [8:0]  rTxShift;
   logic        rTx;
   logic        rDir;
   logic        rBusy;
   logic        rErr;
   logic [15:0] rReqCnt;

   logic        wFall;
   logic        wBitEnd;
   logic        wCfValid;
   logic [2:0]  wLastIdx;
   logic        wIsCrc;
   logic        wAllSent;
   logic [7:0]  wTxByte;
   logic        wErrSet;
   logic        wAccept;
   logic        wLoad;
   logic        wFinish;

   // Two-flop synchronizer plus one history flop for edge detection; all
   // reset high so a reset never looks like a start bit.
   always_ff @(posedge nclk_100m or negedge iRst_n) begin
      if (!iRst_n) begin
         rRxMeta <= 1'b1;
         rRxSync <= 1'b1;
         rRxPrev <= 1'b1;
      end else begin
         rRxMeta <= bus.iRx;
         rRxSync <= rRxMeta;
         rRxPrev <= rRxSync;
      end
   end

   assign wFall    = rRxPrev & ~rRxSync;
   assign wBitEnd  = (rClkCnt == c_BIT_LAST);
   assign wCfValid = (rRxShift == c_CF_POS) || (rRxShift == c_CF_ID);

   // rByteIdx points at the next byte to load; the last index is the CRC.
   assign wLastIdx = (rCf == c_CF_ID) ? 3'd3 : 3'd5;
   assign wIsCrc   = (rByteIdx == wLastIdx);
   assign wAllSent = (rByteIdx == wLastIdx + 3'd1);

   always_comb begin
      wTxByte = rCrc;
      if (!wIsCrc) begin
         case (rByteIdx)
            3'd0:    wTxByte = rCf;
            3'd1:    wTxByte = rSf;
            3'd2:    wTxByte = (rCf == c_CF_ID) ? ENID : rPos[7:0];
            3'd3:    wTxByte = rPos[15:8];
            3'd4:    wTxByte = rPos[23:16];
            default: wTxByte = rCrc;
         endcase
      end
   end

   always_ff @(posedge nclk_100m or negedge iRst_n) begin
      if (!iRst_n) begin
         rState <= IDLE;
      end else begin
         rState <= wStateNxt;
      end
   end

   always_comb begin
      wStateNxt = rState;
      wErrSet   = 1'b0;
      wAccept   = 1'b0;
      wLoad     = 1'b0;
      wFinish   = 1'b0;
      case (rState)
         IDLE: begin
            if (wFall) wStateNxt = RX_START;
         end
         RX_START: begin
            // A line that is high again at mid start bit was only a glitch.
            if (rClkCnt == c_HALF_LAST) wStateNxt = rRxSync ? IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (wBitEnd && (rBitCnt == 4'd7)) wStateNxt = RX_STOP;
         end
         RX_STOP: begin
            if (wBitEnd) begin
               if (!rRxSync) begin
                  wErrSet   = 1'b1;
                  wStateNxt = WAIT_IDLE;
               end else if (wCfValid) begin
                  wAccept   = 1'b1;
                  wStateNxt = TURN;
               end else begin
                  wErrSet   = 1'b1;
                  wStateNxt = IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rRxSync && wBitEnd) wStateNxt = IDLE;
         end
         TURN: begin
            if (rClkCnt == c_TURN_LAST) begin
               wLoad     = 1'b1;
               wStateNxt = TX;
            end
         end
         TX: begin
            if (wBitEnd && (rBitCnt == 4'd9)) begin
               if (wAllSent) begin
                  wFinish   = 1'b1;
                  wStateNxt = IDLE;
               end else begin
                  wLoad = 1'b1;
               end
            end
         end
         default: wStateNxt = IDLE;
      endcase
   end

   always_ff @(posedge nclk_100m or negedge iRst_n) begin
      if (!iRst_n) begin
         rClkCnt  <= '0;
         rBitCnt  <= '0;
         rRxShift <= '0;
         rCf      <= '0;
         rSf      <= '0;
         rPos     <= '0;
         rCrc     <= '0;
         rByteIdx <= '0;
         rTxShift <= '1;
         rTx      <= 1'b1;
         rDir     <= 1'b0;
         rBusy    <= 1'b0;
         rErr     <= 1'b0;
         rReqCnt  <= '0;
      end else begin
         rErr <= wErrSet;

         case (rState)
            IDLE: begin
               rClkCnt <= '0;
               rBitCnt <= '0;
            end
            RX_START: begin
               rClkCnt <= (rClkCnt == c_HALF_LAST) ? 16'd0 : rClkCnt + 16'd1;
            end
            RX_DATA: begin
               if (wBitEnd) begin
                  rClkCnt  <= '0;
                  rBitCnt  <= rBitCnt + 4'd1;
                  rRxShift <= {rRxSync, rRxShift[7:1]};
               end else begin
                  rClkCnt <= rClkCnt + 16'd1;
               end
            end
            RX_STOP: begin
               rClkCnt <= wBitEnd ? 16'd0 : rClkCnt + 16'd1;
            end
            WAIT_IDLE: begin
               // Counts consecutive high clocks; any low restarts the count.
               rClkCnt <= (rRxSync && !wBitEnd) ? rClkCnt + 16'd1 : 16'd0;
            end
            TURN: begin
               rClkCnt <= rClkCnt + 16'd1;
               if (rClkCnt == c_DIR_ON) rDir <= 1'b1;
            end
            TX: begin
               if (wBitEnd) begin
                  rClkCnt <= '0;
                  if (rBitCnt != 4'd9) begin
                     rTx      <= rTxShift[0];
                     rTxShift <= {1'b1, rTxShift[8:1]};
                     rBitCnt  <= rBitCnt + 4'd1;
                  end
               end else begin
                  rClkCnt <= rClkCnt + 16'd1;
               end
            end
            default: rClkCnt <= '0;
         endcase

         // Position and status are frozen here for the whole response.
         if (wAccept) begin
            rCf      <= rRxShift;
            rSf      <= bus.iStatus;
            rPos     <= bus.iPosition;
            rBusy    <= 1'b1;
            rCrc     <= '0;
            rByteIdx <= '0;
         end

         // Start bit goes out directly; data bits and the stop bit follow
         // from the shift register, so bytes abut with no idle gap.
         if (wLoad) begin
            rClkCnt  <= '0;
            rBitCnt  <= '0;
            rTx      <= 1'b0;
            rTxShift <= {1'b1, wTxByte};
            rByteIdx <= rByteIdx + 3'd1;
            if (!wIsCrc) rCrc <= rCrc ^ wTxByte;
         end

         if (wFinish) begin
            rDir    <= 1'b0;
            rBusy   <= 1'b0;
            rReqCnt <= rReqCnt + 16'd1;
         end
      end
   end

   assign bus.oTx      = rTx;
   assign bus.oDir     = rDir;
   assign bus.oBusy    = rBusy;
   assign bus.oErr     = rErr;
   assign bus.oReq_cnt = rReqCnt;

endmodule
`default_nettype wire
